aes_inv_iter: RTL and testbench
===============================

Name: aes_inv_iter

Overview:
- Iterative AES-128 inverse cipher, one round per clock. It decrypts the 128-bit blocks produced by the AES_pipe encryption pipeline.
- Accepts ciphertext and cipher key over a valid/ready handshake and runs the forward key schedule internally to reach round key 10.
- Decrypts while reversing the key schedule on the fly, then presents the plaintext on a valid/ready output.
- Sits on the receive side of the datapath, opposite AES_pipe.

Parameters:
- NR, 10, round count. Only 10 is legal; any other value is an elaboration-time error.

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  asynchronous reset, active-low
- in_valid  input  1  ciphertext/key offered
- in_ready  output  1  block can accept a new job
- ciphertext  input  128  byte 0 in [127:120], FIPS-197 order
- key  input  128  cipher key, same byte order
- out_valid  output  1  plaintext valid
- out_ready  input  1  consumer accepts plaintext
- plaintext  output  128  decrypted block, same byte order

Behaviour:
- Reset (RST low, asynchronous):
  - state=IDLE; in_ready=1; out_valid=0; plaintext=0; internal data, key and round counter regs cleared.
  - Reset mid-operation aborts the job; no output is produced.
- Acceptance: in_valid & in_ready at a rising edge (call it E0) captures ciphertext into data_reg and key into key_reg, and moves the FSM to KEXP.
- in_ready is 1 only in IDLE. in_valid in other states is ignored, with no side effects.
- KEXP (10 cycles, edges E1..E10):
  - Each edge applies one forward key-schedule step with Rcon 01,02,04,08,10,20,40,80,1b,36.
  - After E10, key_reg holds rk10.
- ARK0 (edge E11): data_reg <= data_reg ^ rk10; round counter r=9.
- ROUND (edges E12..E20, r=9..1):
  - rk_r is computed combinationally from key_reg (rk_{r+1}) by the inverse key step, using Rcon(r+1).
  - data_reg <= InvMixColumns(InvSubBytes(InvShiftRows(data_reg)) ^ rk_r).
  - key_reg <= rk_r; r decrements.
- FINAL (edge E21):
  - rk0 is derived the same way.
  - plaintext <= InvSubBytes(InvShiftRows(data_reg)) ^ rk0.
  - out_valid <= 1; state=DONE.
- Latency: out_valid is high in the cycle after E21, i.e. 21 clocks after acceptance.
- DONE:
  - plaintext and out_valid are held stable while out_ready=0.
  - On out_valid & out_ready: out_valid <= 0, state=IDLE, in_ready <= 1 on the same edge. The next acceptance is possible one edge later.
  - No new job is accepted while in DONE.
- S-box:
  - Forward and inverse S-box use GF(2^8) multiplicative inverse plus affine transform (polynomial 0x11b); no 256-entry tables.
  - Inverse and zero map as FIPS-197: S(00)=63, InvS(63)=00.
- Arithmetic: xtime reduction uses 0x1b. InvMixColumns coefficients are 0e,0b,0d,09.

Optional Feature:
- Macro: AES_INV_KEY_CACHE_EN.
- Defined:
  - A 128-bit cached cipher key and cached rk10 are stored, along with a cache_valid bit.
  - Cache is updated on each completed KEXP, and cache_valid is cleared by reset.
  - On acceptance, if cache_valid and key equals the cached key, KEXP is skipped: key_reg <= cached rk10, next state ARK0.
  - With a cache hit, latency is 11 clocks (out_valid high 11 clocks after acceptance).
  - A miss behaves as the base design.
- Undefined: no cache registers; latency is always 21 clocks.

Test Plan:
- Reset: hold RST=0 two cycles, then release -> in_ready=1, out_valid=0, plaintext=0.
- FIPS-197 C.1: key=000102030405060708090a0b0c0d0e0f, ciphertext=69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext=00112233445566778899aabbccddeeff; out_valid rises exactly 21 clocks after acceptance.
- FIPS-197 B with back-pressure: key=2b7e151628aed2a6abf7158809cf4f3c, ct=3925841d02dc09fbdc118597196a0b32; out_ready=0 for 5 cycles -> plaintext=3243f6a8885a308d313198a2e0370734 held stable with out_valid=1 throughout; in_valid pulses during busy are ignored.
- Mid-operation reset: drop RST at clock 7 after acceptance of the C.1 job -> out_valid never asserts; next job (FIPS-197 B) decrypts correctly.
- Loopback: drive AES_pipe with plaintexts 1,2,3,4 under the C.1 key, feed each ciphertext into this block -> outputs 1,2,3,4 in order.
- AES_INV_KEY_CACHE_EN: run C.1 twice back-to-back -> second result has latency 11 and the same plaintext. A third job with the B key -> latency 21, correct plaintext.

Source files
------------

// File: rtl/aes_inv_iter.sv
// aes_inv_iter: iterative AES-128 inverse cipher, one round per clock.
// Expands the cipher key forward to rk10, then decrypts while walking the key schedule backwards.
// Optional rk10 cache for repeated keys: define AES_INV_KEY_CACHE_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | in_ready=1, waiting for a ciphertext/key job
// ST_KEXP  | forward key schedule, one step per clock, rk1..rk10
// ST_ARK0  | initial AddRoundKey with rk10
// ST_ROUND | inverse rounds 9..1, round key derived on the fly
// ST_FINAL | last round (no InvMixColumns), loads plaintext
// ST_DONE  | plaintext held until out_ready
module aes_inv_iter #(
  parameter int NR = 10
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext
);

  if (NR != 10) begin : g_nr_check
    $error("aes_inv_iter: NR must be 10");
  end

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_KEXP  = 3'd1;
  localparam logic [2:0] ST_ARK0  = 3'd2;
  localparam logic [2:0] ST_ROUND = 3'd3;
  localparam logic [2:0] ST_FINAL = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  logic [2:0]   state;
  logic [3:0]   rnd;
  logic [127:0] data_reg;
  logic [127:0] key_reg;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse, and conveniently maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (i != 0) r = gf_mul(r, a);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  // byte 4c+r sits at [127-8*(4c+r) -: 8]; row r rotates right by r columns
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o = '0;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  logic [127:0] key_fwd_next;
  logic [127:0] rk_prev;
  logic [127:0] isr_isb;
  logic [127:0] round_out;
  logic         accept;
  logic         kexp_done;
  logic         cache_hit;
  logic [127:0] cache_rk10;

  // In ROUND/FINAL rnd holds r, and key_reg holds rk_{r+1}, so the step back uses Rcon(r+1)
  assign key_fwd_next = key_fwd(key_reg, rcon(rnd));
  assign rk_prev      = key_inv(key_reg, rcon(rnd + 4'd1));
  assign isr_isb      = inv_shift_sub(data_reg);
  assign round_out    = inv_mix_columns(isr_isb ^ rk_prev);
  assign accept       = (state == ST_IDLE) && in_valid && in_ready;
  assign kexp_done    = (state == ST_KEXP) && (rnd == 4'd10);

`ifdef AES_INV_KEY_CACHE_EN
  logic         cache_valid;
  logic [127:0] cache_key;

  assign cache_hit = cache_valid && (key == cache_key);

  // Remember the key on a miss; rk10 becomes valid once its expansion completes
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cache_valid <= 1'b0;
      cache_key   <= '0;
      cache_rk10  <= '0;
    end else if (accept && !cache_hit) begin
      cache_valid <= 1'b0;
      cache_key   <= key;
    end else if (kexp_done) begin
      cache_valid <= 1'b1;
      cache_rk10  <= key_fwd_next;
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign cache_rk10 = '0;
`endif

  // Main sequencer: key expansion, inverse rounds and output handshake
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= ST_IDLE;
      rnd       <= '0;
      data_reg  <= '0;
      key_reg   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      plaintext <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            data_reg <= ciphertext;
            in_ready <= 1'b0;
            if (cache_hit) begin
              key_reg <= cache_rk10;
              state   <= ST_ARK0;
            end else begin
              key_reg <= key;
              rnd     <= 4'd1;
              state   <= ST_KEXP;
            end
          end
        end
        ST_KEXP: begin
          key_reg <= key_fwd_next;
          if (rnd == 4'd10) state <= ST_ARK0;
          else              rnd   <= rnd + 4'd1;
        end
        ST_ARK0: begin
          data_reg <= data_reg ^ key_reg;
          rnd      <= 4'd9;
          state    <= ST_ROUND;
        end
        ST_ROUND: begin
          data_reg <= round_out;
          key_reg  <= rk_prev;
          rnd      <= rnd - 4'd1;
          if (rnd == 4'd1) state <= ST_FINAL;
        end
        ST_FINAL: begin
          plaintext <= isr_isb ^ rk_prev;
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_iter.sv
// tb_aes_inv_iter: vector table plus hand sequences (back-pressure, mid-job reset) for aes_inv_iter.
// Loopback ciphertexts come from a forward AES-128 model in this bench.
module tb_aes_inv_iter;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [127:0] ciphertext = '0;
  logic [127:0] key = '0;
  logic         in_ready;
  logic         out_valid;
  logic [127:0] plaintext;

  aes_inv_iter #(.NR(10)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready),
    .ciphertext(ciphertext), .key(key),
    .out_valid(out_valid), .out_ready(out_ready),
    .plaintext(plaintext)
  );

`ifdef AES_INV_KEY_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  logic [127:0] exp_q[$];

  bit           m_cv = 1'b0;
  logic [127:0] m_ck = '0;

  typedef struct {
    logic [127:0] ct;
    logic [127:0] k;
    logic [127:0] pt;
    string        nm;
  } vec_t;
  vec_t vecs[7];

  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

  // ---- forward AES-128 model ----
  function automatic logic [7:0] m_xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = m_xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] m_sbox(input logic [7:0] a);
    logic [7:0] inv = 8'h00;
    logic [7:0] c = 8'h63;
    logic [7:0] s;
    for (int b = 1; b < 256; b++)
      if (m_mul(a, 8'(b)) == 8'h01) inv = 8'(b);
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    return s;
  endfunction

  function automatic logic [127:0] m_enc(input logic [127:0] pt, input logic [127:0] k);
    logic [127:0] s, t, rk;
    logic [31:0]  w, n0, n1, n2, n3;
    logic [7:0]   rc, a0, a1, a2, a3;
    rk = k;
    s  = pt ^ rk;
    rc = 8'h01;
    for (int rd = 1; rd <= 10; rd++) begin
      for (int i = 0; i < 16; i++) s[127-8*i -: 8] = m_sbox(s[127-8*i -: 8]);
      t = s;
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[127-8*(4*c+r) -: 8] = t[127-8*(4*((c+r)%4)+r) -: 8];
      if (rd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
          a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
          s[127-32*c -: 8] = m_xt(a0) ^ m_xt(a1) ^ a1 ^ a2 ^ a3;
          s[119-32*c -: 8] = a0 ^ m_xt(a1) ^ m_xt(a2) ^ a2 ^ a3;
          s[111-32*c -: 8] = a0 ^ a1 ^ m_xt(a2) ^ m_xt(a3) ^ a3;
          s[103-32*c -: 8] = m_xt(a0) ^ a0 ^ a1 ^ a2 ^ m_xt(a3);
        end
      end
      w  = rk[31:0];
      n0 = rk[127:96] ^ {m_sbox(w[23:16]) ^ rc, m_sbox(w[15:8]), m_sbox(w[7:0]), m_sbox(w[31:24])};
      n1 = rk[95:64] ^ n0;
      n2 = rk[63:32] ^ n1;
      n3 = rk[31:0] ^ n2;
      rk = {n0, n1, n2, n3};
      s  = s ^ rk;
      rc = m_xt(rc);
    end
    return s;
  endfunction

  // ---- helpers ----
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic int exp_lat(input logic [127:0] k);
    return (CACHE && m_cv && (k == m_ck)) ? 11 : 21;
  endfunction

  task automatic send(input string nm, input logic [127:0] ct, input logic [127:0] k,
                      input logic [127:0] pt, output int acc);
    int w = 0;
    while (!in_ready && w < 60) begin step(); w++; end
    chk({nm, "_in_ready"}, 128'(in_ready), 128'd1);
    ciphertext = ct;
    key        = k;
    in_valid   = 1'b1;
    step();
    in_valid = 1'b0;
    acc = cyc;
    exp_q.push_back(pt);
  endtask

  // wait for out_valid, optionally pulsing in_valid with junk while busy
  task automatic recv(input string nm, input int acc, input int lat, input bit junk);
    int w = 0;
    logic [127:0] e;
    while (!out_valid && w < 60) begin
      if (junk) begin
        in_valid   = ~in_valid;
        ciphertext = {4{$urandom}};
        key        = {4{$urandom}};
      end
      step();
      w++;
    end
    in_valid = 1'b0;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    if (!out_valid) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got out_valid=0 after %0d cycles, required 1", nm, w);
    end else begin
      chk({nm, "_pt"}, plaintext, e);
      chk({nm, "_lat"}, 128'(cyc - acc), 128'(lat));
    end
  endtask

  task automatic note_done(input logic [127:0] k, input int lat);
    if (lat == 21) begin m_cv = 1'b1; m_ck = k; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc, lat, seen;
    logic [127:0] held;

    vecs[0] = '{ct: CT_C1, k: K_C1, pt: PT_C1, nm: "c1"};
    vecs[1] = '{ct: CT_C1, k: K_C1, pt: PT_C1, nm: "c1_again"};
    vecs[2] = '{ct: CT_B,  k: K_B,  pt: PT_B,  nm: "fips_b"};
    for (int i = 0; i < 4; i++)
      vecs[3+i] = '{ct: m_enc(128'(i + 1), K_C1), k: K_C1, pt: 128'(i + 1),
                    nm: $sformatf("loop%0d", i + 1)};

    // reset
    out_ready = 1'b1;
    RST = 1'b0;
    step(); step();
    RST = 1'b1;
    step();
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_plaintext", plaintext, 128'd0);

    // vector table
    for (int i = 0; i < 7; i++) begin
      lat = exp_lat(vecs[i].k);
      send(vecs[i].nm, vecs[i].ct, vecs[i].k, vecs[i].pt, acc);
      recv(vecs[i].nm, acc, lat, 1'b0);
      step();
      chk({vecs[i].nm, "_ovalid_drop"}, 128'(out_valid), 128'd0);
      chk({vecs[i].nm, "_iready_back"}, 128'(in_ready), 128'd1);
      note_done(vecs[i].k, lat);
    end

    // back-pressure, with in_valid noise while busy and while holding
    out_ready = 1'b0;
    lat = exp_lat(K_B);
    send("bp", CT_B, K_B, PT_B, acc);
    recv("bp", acc, lat, 1'b1);
    held = plaintext;
    for (int i = 0; i < 5; i++) begin
      in_valid   = (i % 2 == 0);
      ciphertext = CT_C1;
      key        = K_C1;
      step();
      chk($sformatf("bp_hold_valid%0d", i), 128'(out_valid), 128'd1);
      chk($sformatf("bp_hold_pt%0d", i), plaintext, PT_B);
      chk($sformatf("bp_hold_iready%0d", i), 128'(in_ready), 128'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_release_ovalid", 128'(out_valid), 128'd0);
    chk("bp_release_iready", 128'(in_ready), 128'd1);
    chk("bp_release_pt_kept", plaintext, held);
    note_done(K_B, lat);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (out_valid) seen++;
    end
    chk("bp_no_extra_output", 128'(seen), 128'd0);

    // reset in the middle of a job
    send("abort", CT_C1, K_C1, PT_C1, acc);
    repeat (7) step();
    RST = 1'b0;
    #12;
    RST = 1'b1;
    exp_q.delete();
    m_cv = 1'b0;
    step();
    chk("abort_in_ready", 128'(in_ready), 128'd1);
    chk("abort_out_valid", 128'(out_valid), 128'd0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (out_valid) seen++;
    end
    chk("abort_no_output", 128'(seen), 128'd0);
    lat = exp_lat(K_B);
    send("after_abort", CT_B, K_B, PT_B, acc);
    recv("after_abort", acc, lat, 1'b0);
    step();
    note_done(K_B, lat);

    chk("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
